uart_rx: RTL and testbench

- 8N1 UART receiver that pairs with the existing uart_tx on the same serial link.
- Samples the asynchronous serial line at the middle of each bit and reassembles bytes, LSB first.
- Presents each byte with a one-cycle valid strobe to the downstream consumer (Cipherbox command/data path).
- Default rate: 115200 baud from a 50 MHz clock (434 clocks per bit), matching the transmitter.

---
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx.sv | 113 +++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if - serial line and received-byte bundle for uart_rx.
//   rx          : asynchronous serial line, idles high (line driver -> receiver)
//   data        : last correctly received byte, held until the next valid byte
//   valid       : one-cycle pulse, data is new on this cycle
//   frame_error : one-cycle pulse when the stop bit sampled low
//   active      : receiver busy from start-bit detection until back in IDLE
//   rx_state    : current receiver state encoding (debug)
// master: line driver / byte consumer side.  slave: the receiver.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_error;
    logic       active;
    logic [2:0] rx_state;

    modport master (
        output rx,
        input  data, valid, frame_error, active, rx_state
    );

    modport slave (
        input  rx,
        output data, valid, frame_error, active, rx_state
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx - 8N1 UART receiver, mid-bit sampling, LSB first.
// Ports:
//   clk  : system clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : uart_rx_if.slave (rx in; data/valid/frame_error/active/rx_state out)
//
// state   | meaning
// IDLE    | waiting for a falling edge on an armed (previously high) line
// START   | counting to mid start bit, re-checking it is still low
// DATA    | sampling 8 data bits at their mid points
// STOP    | sampling the stop bit at its mid point
// CLEANUP | one cycle presenting valid or frame_error
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_rx_meta;
    logic          r_rx_s;
    logic [1:0]    r_sync_fill;
    logic          r_armed;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_stop_ok;
    logic          w_cnt_last;
    logic          w_cnt_half;

    assign w_cnt_last = (r_clk_cnt == CNT_LAST);
    assign w_cnt_half = (r_clk_cnt == CNT_HALF);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (r_armed && !r_rx_s) w_state_next = START;
            START:   if (w_cnt_half) w_state_next = r_rx_s ? IDLE : DATA;
            DATA:    if (w_cnt_last && (r_bit_idx == 3'd7)) w_state_next = STOP;
            STOP:    if (w_cnt_last) w_state_next = CLEANUP;
            CLEANUP: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_sync_fill <= 2'b00;
            r_armed     <= 1'b0;
            r_clk_cnt   <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_stop_ok   <= 1'b0;
        end else begin
            r_rx_meta   <= bus.rx;
            r_rx_s      <= r_rx_meta;
            // The sync flops come out of reset high, not from the line; arming
            // waits until rx_s carries a real line sample so a line held low
            // through reset cannot look like a high-then-low start edge.
            r_sync_fill <= {r_sync_fill[0], 1'b1};
            r_state     <= w_state_next;

            r_armed <= (r_state == IDLE) && (w_state_next == IDLE) &&
                       (r_armed || (r_rx_s && r_sync_fill[1]));

            if ((w_state_next != r_state) || (r_state == IDLE) ||
                (r_state == CLEANUP) || w_cnt_last)
                r_clk_cnt <= '0;
            else
                r_clk_cnt <= r_clk_cnt + CW'(1);

            if (r_state == START)
                r_bit_idx <= 3'd0;
            else if ((r_state == DATA) && w_cnt_last) begin
                r_shift[r_bit_idx] <= r_rx_s;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end

            if ((r_state == STOP) && w_cnt_last) begin
                r_stop_ok <= r_rx_s;
                if (r_rx_s)
                    r_data <= r_shift;
            end
        end
    end

    assign bus.data        = r_data;
    assign bus.valid       = (r_state == CLEANUP) && r_stop_ok;
    assign bus.frame_error = (r_state == CLEANUP) && !r_stop_ok;
    assign bus.active      = (r_state == START) || (r_state == DATA) ||
                             (r_state == STOP)  || (r_state == CLEANUP);
    assign bus.rx_state    = r_state;
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    localparam int CPB   = 434;
    localparam int HALF  = (CPB - 1) / 2;
    // cycles from START entry (cycle 0) to the valid/frame_error cycle
    localparam int LAT   = HALF + 1 + 9 * CPB;

    typedef struct {
        int         lo;    // first cycle with active=1
        int         hi;    // last cycle with active=1
        int         kind;  // 0 no output, 1 valid, 2 frame_error
        logic [7:0] d;
    } window_t;

    typedef struct {
        int         n;
        logic [7:0] d;
    } obs_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    int      cyc = 0;
    int      n_chk = 0;
    int      n_fail = 0;
    window_t win_q[$];
    obs_t    obs_q[$];
    int      ferr_q[$];

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    // Per-cycle compare against the frame timeline model.
    initial begin : compare
        logic [7:0] exp_data;
        logic       exp_valid, exp_ferr, exp_act;
        logic [2:0] exp_state;
        int         n;
        exp_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            n = cyc;
            exp_valid = 1'b0;
            exp_ferr  = 1'b0;
            exp_act   = 1'b0;
            exp_state = 3'd0;
            if (rst) begin
                exp_data = 8'h00;
            end else begin
                foreach (win_q[i]) begin
                    if (n >= win_q[i].lo && n <= win_q[i].hi) begin
                        exp_act = 1'b1;
                        if (n == win_q[i].hi && win_q[i].kind != 0)
                            exp_state = 3'd4;
                        else if (n <= win_q[i].lo + HALF)
                            exp_state = 3'd1;
                        else if (n <= win_q[i].lo + HALF + 8 * CPB)
                            exp_state = 3'd2;
                        else
                            exp_state = 3'd3;
                    end
                    if (n == win_q[i].hi && win_q[i].kind == 1) begin
                        exp_valid = 1'b1;
                        exp_data  = win_q[i].d;
                    end
                    if (n == win_q[i].hi && win_q[i].kind == 2)
                        exp_ferr = 1'b1;
                end
            end
            chk("valid", bus.valid, exp_valid);
            chk("frame_error", bus.frame_error, exp_ferr);
            chk("data", bus.data, exp_data);
            chk("active", bus.active, exp_act);
            chk("rx_state", bus.rx_state, exp_state);
            if (bus.valid === 1'b1) obs_q.push_back('{n: n, d: bus.data});
            if (bus.frame_error === 1'b1) ferr_q.push_back(n);
        end
    end

    task automatic drive_bit(input logic v);
        bus.rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    // Must be called at a negedge; the start edge reaches the DUT at the next posedge.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int gap, output int s);
        window_t w;
        s      = cyc + 1;
        w.lo   = s + 2;
        w.hi   = s + 2 + LAT;
        w.kind = stop_ok ? 1 : 2;
        w.d    = b;
        win_q.push_back(w);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        bus.rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin : main
        int         s, s0, s1, s2, base, fbase, n_ok;
        window_t    w;
        logic [7:0] b, pat;
        logic       ok;
        int         gap;

        bus.rx = 1'b1;
        rst    = 1'b1;
        // reset hold with a toggling line
        repeat (20) begin
            @(negedge clk);
            bus.rx = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst    = 1'b0;
        bus.rx = 1'b1;
        repeat (10) @(negedge clk);

        // single byte
        base = obs_q.size();
        send_frame(8'hD1, 1'b1, CPB, s);
        chk("d1_count", obs_q.size() - base, 1);
        if (obs_q.size() > base) begin
            chk("d1_data", obs_q[base].d, 8'hD1);
            chk("d1_latency", obs_q[base].n - s, 4125);
        end

        // back-to-back, no idle gap
        base = obs_q.size();
        send_frame(8'h00, 1'b1, 0, s0);
        send_frame(8'hFF, 1'b1, 0, s1);
        send_frame(8'hA5, 1'b1, 2 * CPB, s2);
        chk("b2b_count", obs_q.size() - base, 3);
        if (obs_q.size() >= base + 3) begin
            chk("b2b_d0", obs_q[base].d, 8'h00);
            chk("b2b_d1", obs_q[base + 1].d, 8'hFF);
            chk("b2b_d2", obs_q[base + 2].d, 8'hA5);
            chk("b2b_gap01", obs_q[base + 1].n - obs_q[base].n, 4340);
            chk("b2b_gap12", obs_q[base + 2].n - obs_q[base + 1].n, 4340);
        end

        // glitch: 100 cycles low
        base = obs_q.size();
        s    = cyc + 1;
        w    = '{lo: s + 2, hi: s + 2 + HALF, kind: 0, d: 8'h00};
        win_q.push_back(w);
        bus.rx = 1'b0;
        repeat (100) @(negedge clk);
        bus.rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("glitch_no_valid", obs_q.size() - base, 0);
        chk("glitch_state", bus.rx_state, 3'd0);
        chk("glitch_active", bus.active, 1'b0);

        // framing error, then a long break
        base  = obs_q.size();
        fbase = ferr_q.size();
        send_frame(8'h3C, 1'b0, 0, s);
        bus.rx = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        chk("break_idle", bus.rx_state, 3'd0);
        bus.rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("ferr_count", ferr_q.size() - fbase, 1);
        chk("ferr_no_valid", obs_q.size() - base, 0);
        chk("ferr_data_kept", bus.data, 8'hA5);
        if (ferr_q.size() > fbase)
            chk("ferr_latency", ferr_q[fbase] - s, 4125);

        // reset during bit 4 of 8'h5A
        base = obs_q.size();
        pat  = 8'h5A;
        s    = cyc + 1;
        w    = '{lo: s + 2, hi: s + 100000, kind: 0, d: 8'h00};
        win_q.push_back(w);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(pat[i]);
        bus.rx = pat[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        win_q[win_q.size() - 1].hi = cyc;
        bus.rx = 1'b1;
        @(negedge clk);
        chk("rst_state", bus.rx_state, 3'd0);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        chk("rst_no_valid", obs_q.size() - base, 0);
        chk("rst_data_cleared", bus.data, 8'h00);
        send_frame(8'h81, 1'b1, CPB, s);
        chk("after_rst_count", obs_q.size() - base, 1);
        chk("after_rst_data", bus.data, 8'h81);

        // random frames
        base = obs_q.size();
        n_ok = 0;
        repeat (6) begin
            b   = 8'($urandom);
            ok  = ($urandom_range(0, 3) != 0);
            gap = ok ? int'($urandom_range(0, 300)) : int'($urandom_range(20, 300));
            if (ok) n_ok++;
            send_frame(b, ok, gap, s);
        end
        repeat (2 * CPB) @(negedge clk);
        chk("rand_count", obs_q.size() - base, n_ok);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
